fp_to_int: RTL and testbench

//  Multi-cycle IEEE-754 single-precision to signed two's-complement integer converter.

---
 rtl/fp_to_int.sv | 211 +++++++++++++++++++++
 tb/tb_fp_to_int.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int.sv
// fp_to_int: multi-cycle IEEE-754 single-precision to signed integer converter.
// Truncates toward zero (C cast semantics). Special operands (NaN, Inf,
// out-of-range, |x| < 1) resolve in the UNPACK cycle; ordinary values walk
// the significand one bit per clock in SHIFT, then apply the sign in SIGN.
// A start request is honoured in every state and abandons any work in flight.

module fp_to_int #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      a,
    output logic [OUT_W-1:0] result,
    output logic             done,
    output logic             invalid,
    output logic             inexact
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [OUT_W-1:0] INT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] INT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
    // Biased exponent at which the magnitude no longer fits in OUT_W-1 bits.
    localparam logic [7:0]       EXP_SAT  = 8'(127 + OUT_W - 1);
    // Biased exponent for which the hidden bit already sits at weight 2^23,
    // i.e. the 24-bit significand needs no shift at all.
    localparam logic [7:0]       EXP_ZERO = 8'd150;
    localparam logic [7:0]       EXP_ONE  = 8'd127;
    localparam logic [7:0]       EXP_MAX  = 8'd255;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        SHIFT,
        SIGN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [31:0] a_reg;     // captured operand
    logic [31:0] mag;       // significand being aligned to the binary point
    logic [4:0]  ctr;       // remaining single-bit shifts
    logic        dir_left;  // 1: shift toward MSB, 0: shift toward LSB
    logic        sticky;    // OR of every bit dropped off the right end

    // ------------------------------------------------------------------
    // Operand decode (from the captured copy, valid in UNPACK)
    // ------------------------------------------------------------------
    logic        sign_bit;
    logic [7:0]  exp_f;
    logic [22:0] mant;
    logic        is_nan;
    logic        is_big;
    logic        is_min_exact;
    logic        is_small;
    logic        is_special;
    logic        shift_left;
    logic [4:0]  shift_amt;

    assign sign_bit     = a_reg[31];
    assign exp_f        = a_reg[30:23];
    assign mant         = a_reg[22:0];

    assign is_nan       = (exp_f == EXP_MAX) && (mant != 23'd0);
    // Infinity also lands here: its exponent is above EXP_SAT and it
    // saturates by sign exactly like any other overflow.
    assign is_big       = (exp_f >= EXP_SAT);
    // -2^(OUT_W-1) is representable, so that single value is not an overflow.
    assign is_min_exact = sign_bit && (exp_f == EXP_SAT) && (mant == 23'd0);
    assign is_small     = (exp_f < EXP_ONE);
    assign is_special   = is_nan || is_big || is_small;

    assign shift_left   = (exp_f > EXP_ZERO);
    // Only reached for exponents 127..EXP_SAT-1, so |E-23| <= 23 fits 5 bits.
    assign shift_amt    = shift_left ? 5'(exp_f - EXP_ZERO) : 5'(EXP_ZERO - exp_f);

    // ------------------------------------------------------------------
    // Special-case outcome, selected in UNPACK
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] sp_result;
    logic             sp_invalid;
    logic             sp_inexact;

    // Resolve NaN / overflow / sub-unity operands to their final flags and value.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the if/else chain can leave it unassigned
        // and infer a latch.
        sp_result  = '0;
        sp_invalid = 1'b0;
        sp_inexact = 1'b0;
        if (is_nan) begin
            sp_result  = INT_MIN;
            sp_invalid = 1'b1;
        end else if (is_big) begin
            if (is_min_exact) begin
                sp_result = INT_MIN;
            end else begin
                sp_result  = sign_bit ? INT_MIN : INT_MAX;
                sp_invalid = 1'b1;
            end
        end else if (is_small) begin
            // Zero (either sign) is exact; anything else below 1.0 loses bits.
            sp_inexact = |a_reg[30:0];
        end
    end

    // ------------------------------------------------------------------
    // Sign application for the normal path
    // ------------------------------------------------------------------
    logic [31:0] mag_signed;

    assign mag_signed = sign_bit ? (32'd0 - mag) : mag;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; a new request always wins over the current walk.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = UNPACK;
        end else begin
            unique case (state)
                IDLE:    state_next = IDLE;
                UNPACK:  state_next = is_special ? DONE : SHIFT;
                SHIFT:   state_next = (ctr == 5'd0) ? SIGN : SHIFT;
                SIGN:    state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: operand capture, significand alignment and result write-back.
    always_ff @(posedge clk) begin
        // NOTE: the whole datapath is reset, not just the control state, so
        // the outputs are defined zeros straight out of reset.
        if (!reset) begin
            a_reg    <= '0;
            mag      <= '0;
            ctr      <= '0;
            dir_left <= 1'b0;
            sticky   <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            invalid  <= 1'b0;
            inexact  <= 1'b0;
        end else if (start) begin
            a_reg   <= a;
            done    <= 1'b0;
            invalid <= 1'b0;
            inexact <= 1'b0;
        end else begin
            unique case (state)
                UNPACK: begin
                    if (is_special) begin
                        result  <= sp_result;
                        invalid <= sp_invalid;
                        inexact <= sp_inexact;
                        done    <= 1'b1;
                    end else begin
                        mag      <= {8'd0, 1'b1, mant};
                        ctr      <= shift_amt;
                        dir_left <= shift_left;
                        sticky   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ctr != 5'd0) begin
                        if (dir_left) begin
                            mag <= {mag[30:0], 1'b0};
                        end else begin
                            mag    <= {1'b0, mag[31:1]};
                            sticky <= sticky | mag[0];
                        end
                        ctr <= ctr - 5'd1;
                    end
                end
                SIGN: begin
                    result  <= mag_signed[OUT_W-1:0];
                    inexact <= sticky;
                    done    <= 1'b1;
                end
                default: begin
                    // IDLE and DONE hold every register.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Directed-vector bench for fp_to_int (OUT_W = 32). Expected values are
// hand-computed from the float encodings; latency is edges after the
// capture edge until done is first seen high.

module tb_fp_to_int;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] result;
    logic        done;
    logic        invalid;
    logic        inexact;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] res;
        logic        inv;
        logic        inex;
        int          lat;
    } vec_t;

    fp_to_int #(.OUT_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .result  (result),
        .done    (done),
        .invalid (invalid),
        .inexact (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge with operand val, then count edges until done.
    task automatic run_conv(input logic [31:0] val, output int lat, output bit timed_out);
        @(negedge clk);
        start = 1'b1;
        a     = val;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        timed_out = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 00000000", result); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++;
        if (invalid !== 1'b0) begin n_fail++; $display("FAIL reset_invalid got %b want 0", invalid); end
        n_tests++;
        if (inexact !== 1'b0) begin n_fail++; $display("FAIL reset_inexact got %b want 0", inexact); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_normal();
        vec_t v[6];
        int   lat;
        bit   to;
        // latency = |E-23| + 3 edges after capture
        v[0] = '{"pi",        32'h40490FDB, 32'h00000003, 1'b0, 1'b1, 25};
        v[1] = '{"neg_123",   32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b1, 20};
        v[2] = '{"exact_2p23",32'h4B000001, 32'h00800001, 1'b0, 1'b0, 3};
        v[3] = '{"left7",     32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 10};
        v[4] = '{"one",       32'h3F800000, 32'h00000001, 1'b0, 1'b0, 26};
        v[5] = '{"neg_1p5",   32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b1, 26};
        for (int i = 0; i < 6; i++) begin
            run_conv(v[i].a, lat, to);
            n_tests++;
            if (to) begin n_fail++; $display("FAIL %s timeout done never rose", v[i].name); end
            n_tests++;
            if (result !== v[i].res) begin n_fail++; $display("FAIL %s result got %h want %h", v[i].name, result, v[i].res); end
            n_tests++;
            if (invalid !== v[i].inv) begin n_fail++; $display("FAIL %s invalid got %b want %b", v[i].name, invalid, v[i].inv); end
            n_tests++;
            if (inexact !== v[i].inex) begin n_fail++; $display("FAIL %s inexact got %b want %b", v[i].name, inexact, v[i].inex); end
            n_tests++;
            if (lat != v[i].lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", v[i].name, lat, v[i].lat); end
        end
    endtask

    task automatic test_saturation();
        vec_t v[5];
        int   lat;
        bit   to;
        v[0] = '{"pos_2p31", 32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        v[1] = '{"neg_2p31", 32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1};
        v[2] = '{"qnan",     32'h7FC00000, 32'h80000000, 1'b1, 1'b0, 1};
        v[3] = '{"neg_inf",  32'hFF800000, 32'h80000000, 1'b1, 1'b0, 1};
        v[4] = '{"pos_inf",  32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        for (int i = 0; i < 5; i++) begin
            run_conv(v[i].a, lat, to);
            n_tests++;
            if (to) begin n_fail++; $display("FAIL %s timeout done never rose", v[i].name); end
            n_tests++;
            if (result !== v[i].res) begin n_fail++; $display("FAIL %s result got %h want %h", v[i].name, result, v[i].res); end
            n_tests++;
            if (invalid !== v[i].inv) begin n_fail++; $display("FAIL %s invalid got %b want %b", v[i].name, invalid, v[i].inv); end
            n_tests++;
            if (inexact !== v[i].inex) begin n_fail++; $display("FAIL %s inexact got %b want %b", v[i].name, inexact, v[i].inex); end
            n_tests++;
            if (lat != v[i].lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", v[i].name, lat, v[i].lat); end
        end
    endtask

    task automatic test_small();
        vec_t v[3];
        int   lat;
        bit   to;
        v[0] = '{"below_one", 32'h3F7FFFFF, 32'h00000000, 1'b0, 1'b1, 1};
        v[1] = '{"neg_zero",  32'h80000000, 32'h00000000, 1'b0, 1'b0, 1};
        v[2] = '{"denorm",    32'h00000001, 32'h00000000, 1'b0, 1'b1, 1};
        for (int i = 0; i < 3; i++) begin
            run_conv(v[i].a, lat, to);
            n_tests++;
            if (to) begin n_fail++; $display("FAIL %s timeout done never rose", v[i].name); end
            n_tests++;
            if (result !== v[i].res) begin n_fail++; $display("FAIL %s result got %h want %h", v[i].name, result, v[i].res); end
            n_tests++;
            if (invalid !== v[i].inv) begin n_fail++; $display("FAIL %s invalid got %b want %b", v[i].name, invalid, v[i].inv); end
            n_tests++;
            if (inexact !== v[i].inex) begin n_fail++; $display("FAIL %s inexact got %b want %b", v[i].name, inexact, v[i].inex); end
            n_tests++;
            if (lat != v[i].lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", v[i].name, lat, v[i].lat); end
        end
    endtask

    // Reset in the middle of a long right-shift walk.
    task automatic test_reset_mid();
        int seen_done = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 32'h40490FDB;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if ({result, done, invalid, inexact} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_mid outputs got r=%h d=%b i=%b x=%b want all 0", result, done, invalid, inexact);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen_done++;
        end
        n_tests++;
        if (seen_done != 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d done cycles want 0", seen_done); end
    endtask

    // A new start mid-walk aborts the old conversion; only 10 ever shows.
    task automatic test_restart();
        int          done_cycles = 0;
        int          bad_results = 0;
        logic [31:0] bad_val     = '0;
        @(negedge clk);
        start = 1'b1;
        a     = 32'hC2F6E979;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        a     = 32'h41200000;
        @(negedge clk);
        start = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_cycles++;
                if (result !== 32'd10 || inexact !== 1'b0 || invalid !== 1'b0) begin
                    bad_results++;
                    bad_val = result;
                end
            end
        end
        n_tests++;
        if (done_cycles == 0) begin n_fail++; $display("FAIL restart_done got 0 done cycles want >0"); end
        n_tests++;
        if (bad_results != 0) begin n_fail++; $display("FAIL restart_result got %h want 0000000a", bad_val); end
    endtask

    // Held start re-captures; start while done=1 drops done on the capture edge.
    task automatic test_back_to_back();
        int lat;
        bit to;
        run_conv(32'h4B000001, lat, to);
        @(negedge clk);
        start = 1'b1;
        a     = 32'h4F000000;
        @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL restart_drops_done got %b want 0", done); end
        @(negedge clk);
        a = 32'h3F7FFFFF;
        @(negedge clk);
        a = 32'h41200000;
        @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL held_start_done got %b want 0", done); end
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_tests++;
        if (lat != 23) begin n_fail++; $display("FAIL held_start_latency got %0d want 23", lat); end
        n_tests++;
        if (result !== 32'd10) begin n_fail++; $display("FAIL held_start_result got %h want 0000000a", result); end
        n_tests++;
        if (invalid !== 1'b0 || inexact !== 1'b0) begin
            n_fail++;
            $display("FAIL held_start_flags got inv=%b inex=%b want 0 0", invalid, inexact);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b1 || result !== 32'd10) begin
            n_fail++;
            $display("FAIL done_hold got d=%b r=%h want 1 0000000a", done, result);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        test_reset();
        test_normal();
        test_saturation();
        test_small();
        test_reset_mid();
        test_restart();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
